// File: rtl/dac_seq_player_pkg.sv
// Shared definitions for the DAC sequence player: Q16.16 format, player
// states, hold-counter width and the hold reload rule.
package dac_seq_player_pkg;

    localparam int FRAC_BITS      = 16;
    localparam int Q_WIDTH        = 32;
    localparam int DAC_BITS       = 14;
    localparam int DAC_CODE_MIN   = 0;
    localparam int DAC_CODE_MAX   = (1 << DAC_BITS) - 1;
    localparam int DAC_IDLE_CODE  = 8192;
    localparam int HOLD_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    // A programmed hold of zero still shows each sample for one cycle.
    function automatic logic [HOLD_WIDTH-1:0] hold_reload(input logic [HOLD_WIDTH-1:0] h);
        return (h == '0) ? HOLD_WIDTH'(1) : h;
    endfunction

endpackage

// File: rtl/dac_seq_player_if.sv
// Host-side bundle of the DAC sequence player: sample write handshake,
// playback control, calibration words and the DAC/status outputs.
interface dac_seq_player_if #(
    parameter int FLOAT_WIDTH = 32,
    parameter int DAC_WIDTH   = 14,
    parameter int DEPTH       = 1024
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   WR_VALID;
    logic [FLOAT_WIDTH-1:0] WR_DATA;
    logic                   WR_READY;
    logic                   START;
    logic                   LOOP;
    logic [15:0]            HOLD_CYCLES;
    logic [FLOAT_WIDTH-1:0] DAC_CAL_GAIN;
    logic [FLOAT_WIDTH-1:0] DAC_CAL_OFFSET;
    logic [DAC_WIDTH-1:0]   DAC_CODE_OUT;
    logic [CW-1:0]          COUNT;
    logic                   BUSY;
    logic                   DONE;

    modport master (
        output WR_VALID, WR_DATA, START, LOOP, HOLD_CYCLES, DAC_CAL_GAIN, DAC_CAL_OFFSET,
        input  WR_READY, DAC_CODE_OUT, COUNT, BUSY, DONE
    );

    modport slave (
        input  WR_VALID, WR_DATA, START, LOOP, HOLD_CYCLES, DAC_CAL_GAIN, DAC_CAL_OFFSET,
        output WR_READY, DAC_CODE_OUT, COUNT, BUSY, DONE
    );

endinterface

// File: rtl/dac_cal_pipe.sv
// Two-stage DAC calibration: registered Q16.16 multiply by gain (offset
// captured alongside), then registered add + saturate to an unsigned code.
module dac_cal_pipe
    import dac_seq_player_pkg::*;
#(
    parameter int FLOAT_WIDTH = 32,
    parameter int DAC_WIDTH   = 14,
    parameter int IDLE_CODE   = 8192
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    input  logic [FLOAT_WIDTH-1:0] gain,
    input  logic [FLOAT_WIDTH-1:0] offset,
    output logic [DAC_WIDTH-1:0]   code_out
);
    localparam int PW = 2 * FLOAT_WIDTH;

    logic signed [PW-1:0]   prod;
    logic [FLOAT_WIDTH-1:0] mul_d, mul_q, off_q;
    logic                   vld_d, vld_q;
    logic [FLOAT_WIDTH:0]   sum;
    logic [DAC_WIDTH-1:0]   sat_code, code_d, code_q;
    logic                   unused_bits;

    // Multiply stage: keep the Q16.16 window of the full product.
    always_comb begin
        prod  = PW'($signed(in_data)) * PW'($signed(gain));
        mul_d = prod[FLOAT_WIDTH+FRAC_BITS-1:FRAC_BITS];
        vld_d = in_valid & ~flush;
    end

    // Add/saturate stage: 33-bit sum cannot wrap; clamp the integer part.
    always_comb begin
        sum = {mul_q[FLOAT_WIDTH-1], mul_q} + {off_q[FLOAT_WIDTH-1], off_q};
        if (sum[FLOAT_WIDTH]) begin
            sat_code = '0;
        end else if (|sum[FLOAT_WIDTH-1:FRAC_BITS+DAC_WIDTH]) begin
            sat_code = '1;
        end else begin
            sat_code = sum[FRAC_BITS+DAC_WIDTH-1:FRAC_BITS];
        end
        code_d = code_q;
        if (flush) begin
            code_d = DAC_WIDTH'(IDLE_CODE);
        end else if (vld_q) begin
            code_d = sat_code;
        end
    end

    always_comb begin
        unused_bits = ^{prod[PW-1:FLOAT_WIDTH+FRAC_BITS], prod[FRAC_BITS-1:0], sum[FRAC_BITS-1:0]};
    end

    // Pipeline registers; the output holds its last code between valid entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q  <= '0;
            off_q  <= '0;
            vld_q  <= 1'b0;
            code_q <= DAC_WIDTH'(IDLE_CODE);
        end else begin
            mul_q  <= mul_d;
            off_q  <= offset;
            vld_q  <= vld_d;
            code_q <= code_d;
        end
    end

    always_comb code_out = code_q;

endmodule

// File: rtl/dac_seq_player.sv
// Host-loaded waveform player: buffers Q16.16 samples, replays them with a
// programmable per-sample hold through the calibration pipe to DAC channel B.
module dac_seq_player
    import dac_seq_player_pkg::*;
#(
    parameter int FLOAT_WIDTH = 32,
    parameter int DAC_WIDTH   = 14,
    parameter int DEPTH       = 1024,
    parameter int IDLE_CODE   = 8192
) (
    input  logic             ADC_CLK,
    input  logic             RST,
    dac_seq_player_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_t                 state_q, state_d;
    logic [AW:0]            count_q, count_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d, hold_load;
    logic                   start_q, start_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   start_rise, wr_ready, wr_fire, last_sample, flush;
    logic [FLOAT_WIDTH-1:0] rd_data_q;
    logic [FLOAT_WIDTH-1:0] mem [DEPTH];
    logic [DAC_WIDTH-1:0]   code;

    // Next-state logic: loading in IDLE, hold/advance in PLAY, rearm from DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        hold_d      = hold_q;
        wr_ready    = 1'b0;
        wr_fire     = 1'b0;
        start_d     = bus.START;
        start_rise  = bus.START & ~start_q;
        hold_load   = hold_reload(bus.HOLD_CYCLES);
        last_sample = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
        // Anything but an active PLAY/DONE leaves the pipe showing the idle code.
        flush       = (state_q == ST_IDLE) || !bus.START;
        rd_vld_d    = ~flush;
        case (state_q)
            ST_IDLE: begin
                wr_ready = (count_q < FULL);
                wr_fire  = bus.WR_VALID & wr_ready;
                if (wr_fire) count_d = count_q + CNT_ONE;
                if (start_rise && (count_q != '0 || wr_fire)) begin
                    state_d  = ST_PLAY;
                    rd_ptr_d = '0;
                    hold_d   = hold_load;
                end
            end
            ST_PLAY: begin
                if (!bus.START) begin
                    state_d = ST_IDLE;
                end else if (hold_q <= HOLD_WIDTH'(1)) begin
                    if (!last_sample) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        hold_d   = hold_load;
                    end else if (bus.LOOP) begin
                        rd_ptr_d = '0;
                        hold_d   = hold_load;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (!bus.START) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge ADC_CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            start_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            start_q  <= start_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Sample buffer: simple dual-port RAM with registered read.
    always_ff @(posedge ADC_CLK) begin
        if (wr_fire) mem[count_q[AW-1:0]] <= bus.WR_DATA;
        rd_data_q <= mem[rd_ptr_q];
    end

    dac_cal_pipe #(
        .FLOAT_WIDTH (FLOAT_WIDTH),
        .DAC_WIDTH   (DAC_WIDTH),
        .IDLE_CODE   (IDLE_CODE)
    ) u_cal (
        .clk      (ADC_CLK),
        .rst      (RST),
        .flush    (flush),
        .in_valid (rd_vld_q),
        .in_data  (rd_data_q),
        .gain     (bus.DAC_CAL_GAIN),
        .offset   (bus.DAC_CAL_OFFSET),
        .code_out (code)
    );

    // Status outputs.
    always_comb begin
        bus.WR_READY     = wr_ready;
        bus.COUNT        = count_q;
        bus.BUSY         = (state_q == ST_PLAY);
        bus.DONE         = (state_q == ST_DONE);
        bus.DAC_CODE_OUT = code;
    end

endmodule

// File: tb/tb_dac_seq_player.sv
// Scoreboard bench for dac_seq_player: stimulus pushes per-cycle expected
// (code, busy, done) derived from the playback rules; a monitor pops/compares.
module tb_dac_seq_player;

    localparam int DEPTH = 1024;
    localparam int IDLE  = 8192;
    localparam int DMAX  = 16383;

    logic clk = 1'b0;
    logic rst;

    dac_seq_player_if #(.FLOAT_WIDTH(32), .DAC_WIDTH(14), .DEPTH(DEPTH)) bus();

    dac_seq_player #(
        .FLOAT_WIDTH (32),
        .DAC_WIDTH   (14),
        .DEPTH       (DEPTH),
        .IDLE_CODE   (IDLE)
    ) dut (
        .ADC_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        bit busy;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ref_buf[DEPTH];
    int   ref_count = 0;
    int   gain   = 0;
    int   offset = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference calibration: real Q16.16 arithmetic with the documented truncations.
    function automatic int cal(input int v);
        longint p, s, c;
        int t;
        p = longint'(v) * longint'(gain);
        t = int'(p >>> 16);
        s = longint'(t) + longint'(offset);
        c = s >>> 16;
        if (c < 0) return 0;
        if (c > DMAX) return DMAX;
        return int'(c);
    endfunction

    function automatic int rand_v();
        return int'($urandom_range(0, 1048576)) - 524288;
    endfunction

    function automatic void push_rec(input int code, input bit busy, input bit done);
        exp_t e;
        e.code = code;
        e.busy = busy;
        e.done = done;
        exp_q.push_back(e);
    endfunction

    // Expected outputs for cycles 1..L after the START edge: sample j shows for
    // cycles 4+j*h .. 3+(j+1)*h; the sequence is n*h cycles long.
    function automatic void push_play(input int n, input int h, input bit loop, input int len);
        for (int k = 1; k <= len; k++) begin
            int j;
            int code;
            if (k <= 3) begin
                code = IDLE;
            end else begin
                j = (k - 4) / h;
                if (loop) j = j % n;
                else if (j > n - 1) j = n - 1;
                code = cal(ref_buf[j]);
            end
            push_rec(code, loop || (k <= n * h), !loop && (k > n * h));
        end
    endfunction

    // Monitor: one expected record per cycle while the scoreboard holds any.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dac_code", 32'(bus.DAC_CODE_OUT), e.code);
            check("busy", 32'(bus.BUSY), 32'(e.busy));
            check("done", 32'(bus.DONE), 32'(e.done));
        end
    end

    task automatic set_cal(input int g, input int o);
        gain = g;
        offset = o;
        bus.DAC_CAL_GAIN = g;
        bus.DAC_CAL_OFFSET = o;
    endtask

    // One write attempt; called and returns at a negedge.
    task automatic write1(input int v);
        check("wr_ready", 32'(bus.WR_READY), 32'(ref_count < DEPTH));
        check("count", 32'(bus.COUNT), ref_count);
        bus.WR_VALID = 1'b1;
        bus.WR_DATA  = v;
        if (ref_count < DEPTH) begin
            ref_buf[ref_count] = v;
            ref_count++;
        end
        @(negedge clk);
        bus.WR_VALID = 1'b0;
    endtask

    // Start playback (optionally writing one sample in the same cycle), run L
    // cycles, then drop START and check the buffer count that remains.
    task automatic run(input int h, input bit loop, input int len, input bit wr_with_start);
        int  hh;
        int  v;
        bit  in_done;
        hh = (h == 0) ? 1 : h;
        bus.HOLD_CYCLES = 16'(h);
        bus.LOOP = loop;
        if (wr_with_start) begin
            v = rand_v();
            check("wr_ready_start", 32'(bus.WR_READY), 32'(ref_count < DEPTH));
            bus.WR_VALID = 1'b1;
            bus.WR_DATA  = v;
            ref_buf[ref_count] = v;
            ref_count++;
        end
        push_play(ref_count, hh, loop, len);
        bus.START = 1'b1;
        @(negedge clk);
        bus.WR_VALID = 1'b0;
        repeat (len - 1) @(negedge clk);
        in_done = !loop && (len > ref_count * hh);
        push_rec(IDLE, 1'b0, 1'b0);
        bus.START = 1'b0;
        if (in_done) ref_count = 0;
        @(negedge clk);
        check("count_after_stop", 32'(bus.COUNT), ref_count);
        check("wr_ready_after_stop", 32'(bus.WR_READY), 32'(ref_count < DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ws, h, lp, len;
        rst = 1'b1;
        bus.WR_VALID = 1'b0;
        bus.WR_DATA = '0;
        bus.START = 1'b0;
        bus.LOOP = 1'b0;
        bus.HOLD_CYCLES = 16'd1;
        set_cal(0, 0);
        repeat (3) @(negedge clk);
        check("reset_code", 32'(bus.DAC_CODE_OUT), IDLE);
        check("reset_busy", 32'(bus.BUSY), 0);
        check("reset_done", 32'(bus.DONE), 0);
        check("reset_count", 32'(bus.COUNT), 0);
        check("reset_wr_ready", 32'(bus.WR_READY), 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed: 1, 2, -1, 3, -3 V; gain 3276 codes/V, offset 8192 codes.
        set_cal(3276 << 16, 8192 << 16);
        write1(65536); write1(131072); write1(-65536); write1(196608); write1(-196608);
        run(3, 1'b0, 5 * 3 + 6, 1'b0);
        write1(65536); write1(131072); write1(-65536); write1(196608); write1(-196608);
        run(3, 1'b1, 5 * 3 * 2 + 4, 1'b0);
        run(3, 1'b0, 7, 1'b0);
        run(3, 1'b0, 5 * 3 + 2, 1'b0);

        // Zero hold: each sample shown for a single cycle.
        write1(rand_v()); write1(rand_v());
        run(0, 1'b0, 2 + 6, 1'b0);

        // Randomised loads/playbacks, including write-with-start and mid-run aborts.
        repeat (12) begin
            set_cal(int'($urandom_range(0, 4000 * 65536)), int'($urandom_range(0, 16384 * 65536)));
            n  = int'($urandom_range(1, 8));
            ws = int'($urandom_range(0, 1));
            h  = int'($urandom_range(0, 4));
            lp = int'($urandom_range(0, 1));
            for (int i = 0; i < n - ws; i++) write1(rand_v());
            len = int'($urandom_range(1, (ref_count + ws) * ((h == 0) ? 1 : h) + 8));
            run(h, lp[0], len, ws[0]);
        end

        // Asynchronous reset in the middle of playback.
        if (ref_count == 0) write1(rand_v());
        write1(rand_v()); write1(rand_v());
        bus.HOLD_CYCLES = 16'd2;
        bus.LOOP = 1'b0;
        bus.START = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_code", 32'(bus.DAC_CODE_OUT), IDLE);
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_done", 32'(bus.DONE), 0);
        check("rst_count", 32'(bus.COUNT), 0);
        check("rst_wr_ready", 32'(bus.WR_READY), 1);
        ref_count = 0;
        @(negedge clk);
        bus.START = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        // START edge with an empty buffer stays idle.
        repeat (6) push_rec(IDLE, 1'b0, 1'b0);
        bus.START = 1'b1;
        repeat (6) @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);

        // Fill to capacity; the extra write is refused.
        set_cal(int'($urandom_range(0, 4000 * 65536)), int'($urandom_range(0, 16384 * 65536)));
        for (int i = 0; i < DEPTH + 1; i++) write1(rand_v());
        check("count_full", 32'(bus.COUNT), DEPTH);
        check("wr_ready_full", 32'(bus.WR_READY), 0);
        run(1, 1'b0, DEPTH + 5, 1'b0);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
